// File: rtl/mem_access_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer_pkg
//   Shared types for the memory-transaction sequencer: the memory operation
//   encoding driven by the control FSM, the sequencer state encoding, and
//   small decode helpers for the operation field.
// ---------------------------------------------------------------------------
package mem_access_sequencer_pkg;

   // Memory operation requested by the control FSM.
   typedef enum logic [1:0] {
      memop_rd  = 2'd0,   // direct read
      memop_wr  = 2'd1,   // direct write
      memop_rdi = 2'd2,   // read through a pointer held in memory
      memop_wri = 2'd3    // write through a pointer held in memory
   } lc3b_memop;

   // Sequencer phases.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,     // waiting for a request
      ST_PTR  = 2'd1,     // reading the indirect pointer
      ST_ACC  = 2'd2,     // final read or write
      ST_DONE = 2'd3      // one-cycle response
   } seq_state_e;

   function automatic logic op_is_indirect(input lc3b_memop op);
      return (op == memop_rdi) || (op == memop_wri);
   endfunction

   function automatic logic op_is_write(input lc3b_memop op);
      return (op == memop_wr) || (op == memop_wri);
   endfunction

endpackage

// File: rtl/mem_access_sequencer_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane helper shared by the write and read paths.
//   Ports:
//     lane       in   byte lane (low address bits) of the access
//     byte_mode  in   1 = byte access, 0 = full word
//     sext       in   byte reads: 1 = sign-extend, 0 = zero-extend
//     wdata_in   in   store data (low byte used for byte stores)
//     wdata_out  out  store data with the low byte replicated into every lane
//     byte_en    out  write lane mask: one-hot for bytes, all-ones for words
//     rdata_in   in   raw memory word
//     rdata_out  out  selected lane extended to WIDTH, or the raw word
// ---------------------------------------------------------------------------
module mem_lane_align #(
   parameter int WIDTH = 16
) (
   input  logic [$clog2(WIDTH/8)-1:0] lane,
   input  logic                       byte_mode,
   input  logic                       sext,
   input  logic [WIDTH-1:0]           wdata_in,
   output logic [WIDTH-1:0]           wdata_out,
   output logic [WIDTH/8-1:0]         byte_en,
   input  logic [WIDTH-1:0]           rdata_in,
   output logic [WIDTH-1:0]           rdata_out
);

   localparam int LANES = WIDTH / 8;

   logic [7:0] sel_byte;

   always_comb begin
      sel_byte = rdata_in[{lane, 3'b000} +: 8];
      if (byte_mode) begin
         // Replicating the byte lets memory pick it up from any lane.
         wdata_out = {LANES{wdata_in[7:0]}};
         byte_en   = LANES'(1) << lane;
         rdata_out = {{(WIDTH-8){sext & sel_byte[7]}}, sel_byte};
      end else begin
         wdata_out = wdata_in;
         byte_en   = '1;
         rdata_out = rdata_in;
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//   Runs one memory transaction per request from the control FSM: word/byte
//   read or write, direct or through one level of pointer indirection.
//   Handles lane alignment, misalignment errors and a per-phase wait timeout.
//
//   Handshake: a request is taken on a rising edge where req_valid=1 and
//   req_ready=1 (IDLE only); req_valid at any other time is ignored and not
//   queued. rsp_valid is a single-cycle pulse with rsp_err; rsp_rdata holds
//   its value until the next response. A memory strobe stays high with stable
//   address/data until the cycle in which mem_resp=1, and is low afterwards.
//
//   Ports:
//     clk, rst_n                clock, asynchronous active-low reset
//     req_valid/req_ready       request handshake
//     req_op/byte/sext/addr/wdata  request fields
//     rsp_valid/rsp_rdata/rsp_err  response
//     mem_address/read/write/wdata/byte_enable  memory request side
//     mem_rdata/mem_resp        memory completion side
// ---------------------------------------------------------------------------
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic               req_byte,
   input  logic               req_sext,
   input  logic [WIDTH-1:0]   req_addr,
   input  logic [WIDTH-1:0]   req_wdata,
   output logic               rsp_valid,
   output logic [WIDTH-1:0]   rsp_rdata,
   output logic               rsp_err,
   output logic [WIDTH-1:0]   mem_address,
   output logic               mem_read,
   output logic               mem_write,
   output logic [WIDTH-1:0]   mem_wdata,
   output logic [WIDTH/8-1:0] mem_byte_enable,
   input  logic [WIDTH-1:0]   mem_rdata,
   input  logic               mem_resp
);

   localparam int LSB = $clog2(WIDTH / 8);
   // TIMEOUT=0 still needs a one-bit counter to keep the logic well formed.
   localparam int CW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   seq_state_e      state_q, state_d;
   lc3b_memop       op_q, op_d;
   logic            byte_q, byte_d;
   logic            sext_q, sext_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

   logic [WIDTH-1:0]   eff_addr;
   logic               misaligned;
   logic               timeout_hit;
   logic [WIDTH-1:0]   align_wdata;
   logic [WIDTH/8-1:0] align_be;
   logic [WIDTH-1:0]   align_rdata;

   // Address of the current phase: the pointer read always uses the latched
   // address; the final access goes through the fetched pointer if indirect.
   always_comb begin
      eff_addr = addr_q;
      if (state_q == ST_ACC && op_is_indirect(op_q)) begin
         eff_addr = ptr_q;
      end
      // Pointer reads are always full words, so only ACC honours byte mode.
      misaligned  = ((state_q == ST_PTR) || !byte_q) && (eff_addr[LSB-1:0] != '0);
      timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST) && !mem_resp;
   end

   mem_lane_align #(
      .WIDTH(WIDTH)
   ) u_lane_align (
      .lane      (eff_addr[LSB-1:0]),
      .byte_mode (byte_q),
      .sext      (sext_q),
      .wdata_in  (wdata_q),
      .wdata_out (align_wdata),
      .byte_en   (align_be),
      .rdata_in  (mem_rdata),
      .rdata_out (align_rdata)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= memop_rd;
         byte_q     <= 1'b0;
         sext_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ptr_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         byte_q     <= byte_d;
         sext_q     <= sext_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ptr_q      <= ptr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      byte_d     = byte_q;
      sext_d     = sext_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ptr_d      = ptr_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d       = lc3b_memop'(req_op);
               byte_d     = req_byte;
               sext_d     = req_sext;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               err_d      = 1'b0;
               wait_cnt_d = '0;
               state_d    = op_is_indirect(lc3b_memop'(req_op)) ? ST_PTR : ST_ACC;
            end
         end
         ST_PTR, ST_ACC: begin
            if (misaligned) begin
               // No strobe is issued for a misaligned phase; fail straight away.
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_DONE;
            end else if (mem_resp) begin
               // A response on the last allowed cycle still counts.
               wait_cnt_d = '0;
               if (state_q == ST_PTR) begin
                  ptr_d   = mem_rdata;
                  state_d = ST_ACC;
               end else begin
                  rdata_d = op_is_write(op_q) ? '0 : align_rdata;
                  state_d = ST_DONE;
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_DONE;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      req_ready       = (state_q == ST_IDLE);
      rsp_valid       = (state_q == ST_DONE);
      rsp_err         = (state_q == ST_DONE) && err_q;
      rsp_rdata       = rdata_q;
      mem_address     = eff_addr;
      mem_wdata       = align_wdata;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = '1;
      if (!misaligned) begin
         if (state_q == ST_PTR) begin
            mem_read = 1'b1;
         end else if (state_q == ST_ACC) begin
            mem_read  = !op_is_write(op_q);
            mem_write = op_is_write(op_q);
         end
      end
      if (state_q == ST_ACC && op_is_write(op_q)) begin
         mem_byte_enable = align_be;
      end
   end

endmodule
